// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU, branch, MDU and forwarding
// codes plus the MDU sequencer state enum.
package exe_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] MDU_MUL   = 2'b00;
    localparam logic [1:0] MDU_MULHU = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_REMU  = 2'b11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iterative.sv
// Iterative unsigned multiply/divide: one shift-add or restoring-subtract
// step per cycle, XLEN steps per operation, result held for one DONE cycle.
module mdu_iterative
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    mdu_state_e      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier -> product low / dividend -> quotient
    logic [XLEN-1:0] m_q, m_d;       // multiplicand or divisor
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_shift;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        m_d       = m_q;
        busy      = 1'b0;
        done      = 1'b0;
        sum       = {1'b0, acc_q} + {1'b0, m_q};
        rem_shift = {acc_q, lo_q[XLEN-1]};

        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    busy    = 1'b1;
                    state_d = MDU_RUN;
                    count_d = '0;
                    op_d    = op;
                    acc_d   = '0;
                    if (op[1]) begin
                        m_d  = b;
                        lo_d = a;
                    end else begin
                        m_d  = a;
                        lo_d = b;
                    end
                end
            end
            MDU_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = MDU_IDLE;
                    count_d = '0;
                end else begin
                    if (!op_q[1]) begin
                        if (lo_q[0]) {acc_d, lo_d} = {sum, lo_q[XLEN-1:1]};
                        else         {acc_d, lo_d} = {1'b0, acc_q, lo_q[XLEN-1:1]};
                    end else if (rem_shift >= {1'b0, m_q}) begin
                        acc_d = XLEN'(rem_shift - {1'b0, m_q});
                        lo_d  = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = rem_shift[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], 1'b0};
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(XLEN - 1)) state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                done    = 1'b1;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase

        case (op_q)
            MDU_MUL:   result = lo_q;
            MDU_MULHU: result = acc_q;
            MDU_DIVU:  result = lo_q;
            default:   result = acc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            count_q <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
        end
    end

endmodule

// File: rtl/execute_cycle_mdu.sv
// RISC-V execute stage: forwarding, ALU, branch/jump resolution, optional
// iterative MDU that stalls via busy_E, and the EX/MEM pipeline register.
module execute_cycle_mdu
    import exe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RADDR  = 5,
    parameter int MDU_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             ResultSrcE,
    input  logic             ALUSrcE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic [2:0]       BranchTypeE,
    input  logic [3:0]       ALUControlE,
    input  logic             MduEnE,
    input  logic [1:0]       MduOpE,
    input  logic             FlushE,
    input  logic [XLEN-1:0]  RD1_E,
    input  logic [XLEN-1:0]  RD2_E,
    input  logic [XLEN-1:0]  Imm_Ext_E,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  PCPlus4E,
    input  logic [RADDR-1:0] RD_E,
    input  logic [1:0]       ForwardA_E,
    input  logic [1:0]       ForwardB_E,
    input  logic [XLEN-1:0]  ResultW,
    output logic             PCSrcE,
    output logic [XLEN-1:0]  PCTargetE,
    output logic             busy_E,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             ResultSrcM,
    output logic [RADDR-1:0] RD_M,
    output logic [XLEN-1:0]  ALU_ResultM,
    output logic [XLEN-1:0]  WriteDataM,
    output logic [XLEN-1:0]  PCPlus4M
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]  fwd_a, fwd_b, src_b, alu_res;
    logic [SHW-1:0]   shamt;
    logic             br_cond;
    logic             mdu_busy, mdu_done;
    logic [XLEN-1:0]  mdu_result;

    logic             reg_write_m_q, reg_write_m_d;
    logic             mem_write_m_q, mem_write_m_d;
    logic             result_src_m_q, result_src_m_d;
    logic [RADDR-1:0] rd_m_q, rd_m_d;
    logic [XLEN-1:0]  alu_result_m_q, alu_result_m_d;
    logic [XLEN-1:0]  write_data_m_q, write_data_m_d;
    logic [XLEN-1:0]  pc_plus4_m_q, pc_plus4_m_d;

    always_comb begin
        case (ForwardA_E)
            FWD_WB:  fwd_a = ResultW;
            FWD_MEM: fwd_a = alu_result_m_q;
            default: fwd_a = RD1_E;
        endcase
        case (ForwardB_E)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = alu_result_m_q;
            default: fwd_b = RD2_E;
        endcase
        src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
        shamt = src_b[SHW-1:0];
    end

    always_comb begin
        case (ALUControlE)
            ALU_ADD:  alu_res = fwd_a + src_b;
            ALU_SUB:  alu_res = fwd_a - src_b;
            ALU_AND:  alu_res = fwd_a & src_b;
            ALU_OR:   alu_res = fwd_a | src_b;
            ALU_XOR:  alu_res = fwd_a ^ src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_a < src_b};
            ALU_SLL:  alu_res = fwd_a << shamt;
            ALU_SRL:  alu_res = fwd_a >> shamt;
            ALU_SRA:  alu_res = $signed(fwd_a) >>> shamt;
            default:  alu_res = '0;
        endcase
    end

    // Branches compare the forwarded register pair, never the immediate.
    always_comb begin
        case (BranchTypeE)
            BR_EQ:   br_cond = (fwd_a == fwd_b);
            BR_NE:   br_cond = (fwd_a != fwd_b);
            BR_LT:   br_cond = ($signed(fwd_a) < $signed(fwd_b));
            BR_GE:   br_cond = ($signed(fwd_a) >= $signed(fwd_b));
            BR_LTU:  br_cond = (fwd_a < fwd_b);
            BR_GEU:  br_cond = (fwd_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = !FlushE && !mdu_busy && (JumpE || (BranchE && br_cond));
    assign busy_E    = mdu_busy;

    generate
        if (MDU_EN != 0) begin : gen_mdu
            mdu_iterative #(.XLEN(XLEN)) u_mdu (
                .clk    (clk),
                .rst    (rst),
                .start  (MduEnE && !FlushE),
                .abort  (FlushE),
                .op     (MduOpE),
                .a      (fwd_a),
                .b      (fwd_b),
                .busy   (mdu_busy),
                .done   (mdu_done),
                .result (mdu_result)
            );
        end else begin : gen_no_mdu
            assign mdu_busy   = 1'b0;
            assign mdu_done   = 1'b0;
            assign mdu_result = '0;
        end
    endgenerate

    // A stalled or flushed cycle leaves a zeroed bubble in EX/MEM.
    always_comb begin
        reg_write_m_d  = 1'b0;
        mem_write_m_d  = 1'b0;
        result_src_m_d = 1'b0;
        rd_m_d         = '0;
        alu_result_m_d = '0;
        write_data_m_d = '0;
        pc_plus4_m_d   = '0;
        if (!mdu_busy && !FlushE) begin
            reg_write_m_d  = RegWriteE;
            mem_write_m_d  = MemWriteE;
            result_src_m_d = ResultSrcE;
            rd_m_d         = RD_E;
            alu_result_m_d = mdu_done ? mdu_result : alu_res;
            write_data_m_d = fwd_b;
            pc_plus4_m_d   = PCPlus4E;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= 1'b0;
            rd_m_q         <= '0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
        end else begin
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
            rd_m_q         <= rd_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
        end
    end

    assign RegWriteM   = reg_write_m_q;
    assign MemWriteM   = mem_write_m_q;
    assign ResultSrcM  = result_src_m_q;
    assign RD_M        = rd_m_q;
    assign ALU_ResultM = alu_result_m_q;
    assign WriteDataM  = write_data_m_q;
    assign PCPlus4M    = pc_plus4_m_q;

endmodule
